// File: rtl/mem_writer.sv
// Sequential loader: stores a valid/ready word stream into a DEPTH-entry memory from address 0,
// with a registered read port. Define MEM_WRITER_WRAP_EN for circular (wrapping) loads.
module mem_writer #(
    parameter int unsigned N      = 7,
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [CNT_W-1:0]  wr_count,
    output logic              busy,
    output logic              done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [N-1:0]      rd_data
);

    typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic                done_q, done_d;
    logic [N-1:0]        rd_data_q, rd_data_d;
    logic                mem_we;
    logic                last_addr;
    logic [N-1:0]        mem_q [DEPTH];

    assign last_addr = (wr_addr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_count_d = wr_count_q;
        done_d     = done_q;
        mem_we     = 1'b0;
        if (start) begin
            // start wins over a same-cycle transfer; that word is dropped
            state_d    = StLoad;
            wr_addr_d  = '0;
            wr_count_d = '0;
            done_d     = 1'b0;
        end else if (wr_valid && state_q == StLoad) begin
            mem_we     = 1'b1;
            wr_addr_d  = last_addr ? '0 : wr_addr_q + 1'b1;
            wr_count_d = (wr_count_q == CNT_W'(DEPTH)) ? wr_count_q : wr_count_q + 1'b1;
            if (last_addr) begin
                done_d = 1'b1;
`ifdef MEM_WRITER_WRAP_EN
                state_d = StLoad;
`else
                state_d = StFull;
`endif
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_en && ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH))) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_count_q <= wr_count_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Memory is deliberately not reset so a reset mid-load keeps earlier words.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[wr_addr_q] <= wr_data;
        end
    end

    assign wr_ready = (state_q == StLoad);
    assign busy     = (state_q == StLoad);
    assign done     = done_q;
    assign wr_count = wr_count_q;
    assign rd_data  = rd_data_q;

endmodule
